// File: rtl/jt12_eg_pkg.sv
// Shared types and rate helpers for the time-multiplexed envelope generator.
// Used by jt12_eg_step and jt12_eg_tdm; optional AM/TL output summing is
// enabled in the top by defining JT12_EG_AM_EN.
package jt12_eg_pkg;

   typedef enum logic [1:0] {
      ATTACK  = 2'd0,
      DECAY   = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } eg_state_e;

   // Effective 6-bit rate: doubled base rate plus key scaling, clamped to 63.
   function automatic logic [5:0] eff_rate(input logic [4:0] base,
                                           input logic [4:0] keycode,
                                           input logic [1:0] ks);
      logic [4:0] kscl;
      logic [6:0] sum;
      kscl = keycode >> (2'd3 - ks);
      sum  = {1'b0, base, 1'b0} + {2'b00, kscl};
      if (base == 5'd0) return 6'd0;
      if (sum > 7'd63) return 6'd63;
      return 6'(sum);
   endfunction

   // Number of low counter bits that must be zero for a step to occur.
   function automatic logic [3:0] step_shift(input logic [5:0] rate);
      logic [5:0] hi;
      hi = rate >> 2;
      if (hi >= 6'd11) return 4'd0;
      return 4'(6'd11 - hi);
   endfunction

   // Per-step increment: fast rates move by more than one unit per step.
   function automatic logic [4:0] step_amount(input logic [5:0] rate);
      logic [5:0] hi;
      hi = rate >> 2;
      if (rate >= 6'd48) return 5'd1 << (hi - 6'd11);
      return 5'd1;
   endfunction

   // Decay-to-sustain threshold; sl=15 means "decay all the way to silence".
   function automatic logic [31:0] sustain_thr(input logic [3:0] sl, input int egw);
      if (sl == 4'hF) return (32'd1 << egw) - 32'd1;
      return 32'(sl) << (egw - 5);
   endfunction

endpackage

// File: rtl/jt12_eg_step.sv
// Combinational next-level / next-state logic for one envelope slot visit.
module jt12_eg_step
   import jt12_eg_pkg::*;
#(
   parameter int EGW  = 10,
   parameter int CNTW = 15
) (
   input  logic [5:0]      rate_i,
   input  logic            attack_instant_i,
   input  logic [CNTW-1:0] eg_cnt_i,
   input  logic [EGW-1:0]  level_i,
   input  eg_state_e       state_i,
   input  logic            keyon_edge_i,
   input  logic            keyoff_edge_i,
   input  logic [3:0]      sl_i,
   output logic [EGW-1:0]  level_o,
   output eg_state_e       state_o
);

   localparam logic [EGW-1:0] MAX_LEVEL = '1;

   logic [3:0]  shift;
   logic [4:0]  amount;
   logic [31:0] mask;
   logic [31:0] dec;
   logic [31:0] inc;
   logic [31:0] thr;
   logic        do_step;

   // Key edges take priority; otherwise step the level and move between states.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latches.
      shift   = step_shift(rate_i);
      amount  = step_amount(rate_i);
      mask    = (32'd1 << shift) - 32'd1;
      do_step = (rate_i != 6'd0) && ((32'(eg_cnt_i) & mask) == 32'd0);
      dec     = ((32'(level_i) * 32'(amount)) >> 4) + 32'd1;
      inc     = 32'(level_i) + 32'(amount);
      thr     = sustain_thr(sl_i, EGW);
      level_o = level_i;
      state_o = state_i;
      if (keyon_edge_i) begin
         state_o = ATTACK;
         if (attack_instant_i) level_o = '0;
      end else if (keyoff_edge_i) begin
         state_o = RELEASE;
      end else if (state_i == ATTACK) begin
         if (do_step) level_o = (dec >= 32'(level_i)) ? '0 : level_i - EGW'(dec);
         if (level_o == '0) state_o = DECAY;
      end else begin
         if (do_step) level_o = (inc > 32'(MAX_LEVEL)) ? MAX_LEVEL : EGW'(inc);
         if (state_i == DECAY && 32'(level_o) >= thr) state_o = SUSTAIN;
      end
   end

endmodule

// File: rtl/jt12_eg_tdm.sv
// Time-multiplexed ADSR envelope generator: one slot visited per clk_en,
// per-slot level/state held in indexed registers.
// Define JT12_EG_AM_EN to add tl/am inputs summed into eg_o.
module jt12_eg_tdm
   import jt12_eg_pkg::*;
#(
   parameter int SLOTS = 24,
   parameter int EGW   = 10,
   parameter int CNTW  = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clk_en,
   output logic [$clog2(SLOTS)-1:0] slot_o,
   input  logic                     keyon,
   input  logic [4:0]               ar,
   input  logic [4:0]               d1r,
   input  logic [4:0]               d2r,
   input  logic [3:0]               rr,
   input  logic [3:0]               sl,
   input  logic [4:0]               keycode,
   input  logic [1:0]               ks,
   output logic [EGW-1:0]           eg_o,
   output logic [$clog2(SLOTS)-1:0] eg_slot_o
`ifdef JT12_EG_AM_EN
   ,
   input  logic [6:0]               tl,
   input  logic [EGW-1:0]           am
`endif
);

   localparam int SW = $clog2(SLOTS);
   localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

   logic [SW-1:0]    slot_q;
   logic [CNTW-1:0]  cnt_q;
   logic [EGW-1:0]   level_q [SLOTS];
   eg_state_e        state_q [SLOTS];
   logic [SLOTS-1:0] keyon_last_q;
   logic [EGW-1:0]   eg_q;
   logic [SW-1:0]    eg_slot_q;

   logic [EGW-1:0] cur_level;
   logic [EGW-1:0] next_level;
   eg_state_e      cur_state;
   eg_state_e      next_state;
   logic [4:0]     base_rate;
   logic [5:0]     rate;
   logic [5:0]     rate_attack;
   logic           kon_edge;
   logic           koff_edge;
   logic [EGW-1:0] eg_d;

   // Fetch the visited slot and derive its active rate and key edges.
   always_comb begin
      cur_level = level_q[slot_q];
      cur_state = state_q[slot_q];
      kon_edge  = keyon & ~keyon_last_q[slot_q];
      koff_edge = ~keyon & keyon_last_q[slot_q];
      case (cur_state)
         ATTACK:  base_rate = ar;
         DECAY:   base_rate = d1r;
         SUSTAIN: base_rate = d2r;
         default: base_rate = {rr, 1'b1};
      endcase
      rate        = eff_rate(base_rate, keycode, ks);
      rate_attack = eff_rate(ar, keycode, ks);
   end

   jt12_eg_step #(
      .EGW  (EGW),
      .CNTW (CNTW)
   ) u_step (
      .rate_i           (rate),
      .attack_instant_i (rate_attack >= 6'd62),
      .eg_cnt_i         (cnt_q),
      .level_i          (cur_level),
      .state_i          (cur_state),
      .keyon_edge_i     (kon_edge),
      .keyoff_edge_i    (koff_edge),
      .sl_i             (sl),
      .level_o          (next_level),
      .state_o          (next_state)
   );

`ifdef JT12_EG_AM_EN
   logic [EGW+1:0] eg_sum;

   // Add total level and amplitude modulation to the output only, saturating.
   always_comb begin
      eg_sum = {2'b00, next_level} + ((EGW+2)'(tl) << (EGW - 7)) + {2'b00, am};
      eg_d   = (|eg_sum[EGW+1:EGW]) ? '1 : eg_sum[EGW-1:0];
   end
`else
   assign eg_d = next_level;
`endif

   // Advance slot and envelope counter, commit the visited slot, register output.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments only.
      if (rst) begin
         slot_q       <= '0;
         cnt_q        <= '0;
         keyon_last_q <= '0;
         eg_q         <= '1;
         eg_slot_q    <= '0;
         // NOTE: per-slot storage is flops, not RAM, so every entry is reset.
         for (int i = 0; i < SLOTS; i++) begin
            level_q[i] <= '1;
            state_q[i] <= RELEASE;
         end
      end else if (clk_en) begin
         level_q[slot_q]      <= next_level;
         state_q[slot_q]      <= next_state;
         keyon_last_q[slot_q] <= keyon;
         eg_q                 <= eg_d;
         eg_slot_q            <= slot_q;
         if (slot_q == LAST_SLOT) begin
            slot_q <= '0;
            cnt_q  <= cnt_q + CNTW'(1);
         end else begin
            slot_q <= slot_q + SW'(1);
         end
      end
   end

   assign slot_o    = slot_q;
   assign eg_o      = eg_q;
   assign eg_slot_o = eg_slot_q;

endmodule

// File: tb/tb_jt12_eg_tdm.sv
// Scoreboard bench for jt12_eg_tdm: a behavioural envelope model predicts each
// visit's output; a monitor compares DUT outputs every cycle.
module tb_jt12_eg_tdm;

   localparam int SLOTS = 4;
   localparam int EGW   = 10;
   localparam int CNTW  = 12;
   localparam int SW    = $clog2(SLOTS);
   localparam int MAXL  = (1 << EGW) - 1;
   localparam int S_ATK = 0, S_DEC = 1, S_SUS = 2, S_REL = 3;

   logic           clk = 1'b0;
   logic           rst, clk_en, keyon;
   logic [4:0]     ar, d1r, d2r, keycode;
   logic [3:0]     rr, sl;
   logic [1:0]     ks;
   logic [SW-1:0]  slot_o, eg_slot_o;
   logic [EGW-1:0] eg_o;

   jt12_eg_tdm #(.SLOTS(SLOTS), .EGW(EGW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .slot_o(slot_o), .keyon(keyon),
      .ar(ar), .d1r(d1r), .d2r(d2r), .rr(rr), .sl(sl), .keycode(keycode), .ks(ks),
      .eg_o(eg_o), .eg_slot_o(eg_slot_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-slot stimulus configuration, applied when that slot is next visited.
   logic       c_keyon [SLOTS];
   logic [4:0] c_ar [SLOTS], c_d1r [SLOTS], c_d2r [SLOTS], c_kc [SLOTS];
   logic [3:0] c_rr [SLOTS], c_sl [SLOTS];
   logic [1:0] c_ks [SLOTS];

   // Reference model state.
   int m_level [SLOTS];
   int m_state [SLOTS];
   int m_last  [SLOTS];
   int m_slot = 0, m_cnt = 0, m_last_visit = -1;
   bit m_init = 0;

   typedef struct { int slot; int eg; } exp_t;
   exp_t exp_q[$];

   function automatic int rate_of(input int base, input int kc, input int kss);
      int r;
      if (base == 0) return 0;
      r = 2 * base + (kc >> (3 - kss));
      return (r > 63) ? 63 : r;
   endfunction

   task automatic model_visit(input int s);
      int st, lv, base, r, ra, sh, amt, thr;
      bit stepping;
      st = m_state[s];
      lv = m_level[s];
      ra = rate_of(int'(ar), int'(keycode), int'(ks));
      case (st)
         S_ATK:   base = int'(ar);
         S_DEC:   base = int'(d1r);
         S_SUS:   base = int'(d2r);
         default: base = 2 * int'(rr) + 1;
      endcase
      r        = rate_of(base, int'(keycode), int'(ks));
      sh       = 11 - r / 4;
      if (sh < 0) sh = 0;
      stepping = (r != 0) && ((m_cnt % (1 << sh)) == 0);
      amt      = (r >= 48) ? (1 << (r / 4 - 11)) : 1;
      thr      = (sl == 4'hF) ? MAXL : int'(sl) * (1 << (EGW - 5));
      if (keyon && m_last[s] == 0) begin
         st = S_ATK;
         if (ra >= 62) lv = 0;
      end else if (!keyon && m_last[s] == 1) begin
         st = S_REL;
      end else if (st == S_ATK) begin
         if (stepping) lv = lv - ((lv * amt) / 16 + 1);
         if (lv < 0) lv = 0;
         if (lv == 0) st = S_DEC;
      end else begin
         if (stepping) lv = (lv + amt > MAXL) ? MAXL : lv + amt;
         if (st == S_DEC && lv >= thr) st = S_SUS;
      end
      m_level[s]   = lv;
      m_state[s]   = st;
      m_last[s]    = keyon ? 1 : 0;
      m_last_visit = s;
      exp_q.push_back('{s, lv});
      if (s == SLOTS - 1) begin
         m_slot = 0;
         m_cnt  = (m_cnt + 1) % (1 << CNTW);
      end else begin
         m_slot = s + 1;
      end
   endtask

   // Model: update on every active edge, push the expected output.
   initial begin
      forever begin
         @(posedge clk);
         if (rst === 1'b1) begin
            for (int i = 0; i < SLOTS; i++) begin
               m_level[i] = MAXL;
               m_state[i] = S_REL;
               m_last[i]  = 0;
            end
            m_slot = 0;
            m_cnt = 0;
            m_last_visit = -1;
            exp_q.delete();
            exp_q.push_back('{0, MAXL});
            m_init = 1;
         end else if (clk_en === 1'b1 && m_init) begin
            model_visit(m_slot);
         end
      end
   end

   // Monitor: adopt newly presented expectations and compare outputs every cycle.
   initial begin
      exp_t e;
      int cur_eg = MAXL, cur_slot = 0;
      forever begin
         @(posedge clk);
         #1;
         if (m_init) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               cur_eg = e.eg;
               cur_slot = e.slot;
            end
            check("eg_o", 32'(eg_o), cur_eg);
            check("eg_slot_o", 32'(eg_slot_o), cur_slot);
            check("slot_o", 32'(slot_o), m_slot);
         end
      end
   end

   task automatic apply(input int s);
      keyon   = c_keyon[s];
      ar      = c_ar[s];
      d1r     = c_d1r[s];
      d2r     = c_d2r[s];
      rr      = c_rr[s];
      sl      = c_sl[s];
      keycode = c_kc[s];
      ks      = c_ks[s];
   endtask

   task automatic run(input int n, input int en_pct);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst    = 1'b0;
         clk_en = ($urandom_range(99) < en_pct);
         apply(m_slot);
      end
   endtask

   // Clock with clk_en high until slot s has just been visited.
   task automatic to_visit(input int s);
      int guard = 0;
      do begin
         @(negedge clk);
         rst = 1'b0;
         clk_en = 1'b1;
         apply(m_slot);
         @(posedge clk);
         #2;
         guard++;
      end while (m_last_visit != s && guard < 2 * SLOTS);
      check("visit_slot", 32'(eg_slot_o), s);
   endtask

   task automatic cfg_slot(input int s, input logic k, input int a, input int d1,
                           input int d2, input int r, input int sv);
      c_keyon[s] = k;
      c_ar[s] = 5'(a); c_d1r[s] = 5'(d1); c_d2r[s] = 5'(d2);
      c_rr[s] = 4'(r); c_sl[s] = 4'(sv); c_kc[s] = 5'd0; c_ks[s] = 2'd0;
   endtask

   task automatic cfg_random(input int s);
      c_keyon[s] = 1'($urandom_range(1));
      c_ar[s] = 5'($urandom_range(31)); c_d1r[s] = 5'($urandom_range(31));
      c_d2r[s] = 5'($urandom_range(31)); c_rr[s] = 4'($urandom_range(15));
      c_sl[s] = 4'($urandom_range(15)); c_kc[s] = 5'($urandom_range(31));
      c_ks[s] = 2'($urandom_range(3));
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         rst = 1'b1;
         clk_en = 1'b0;
      end
      @(negedge clk);
      check("rst_slot_o", 32'(slot_o), 0);
      check("rst_eg_o", 32'(eg_o), 32'h3FF);
      check("rst_eg_slot_o", 32'(eg_slot_o), 0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clk_en = 1'b0;
      for (int s = 0; s < SLOTS; s++) cfg_slot(s, 1'b0, 0, 0, 0, 0, 0);
      apply(0);
      do_reset(2);

      // First round: every slot still silent.
      for (int s = 0; s < SLOTS; s++) begin
         to_visit(s);
         check("idle_eg", 32'(eg_o), 32'h3FF);
      end

      // Slot 3: instant attack, decay to sl=1 (threshold 32), hold in sustain.
      cfg_slot(3, 1'b1, 31, 31, 0, 0, 1);
      to_visit(3); check("inst_attack", 32'(eg_o), 0);
      to_visit(3); check("attack_to_decay", 32'(eg_o), 0);
      to_visit(3); check("decay_16", 32'(eg_o), 16);
      to_visit(3); check("decay_32", 32'(eg_o), 32);
      to_visit(3); check("sustain_hold", 32'(eg_o), 32);

      // Key-off with rr=15: edge visit holds, then +16 per visit.
      cfg_slot(3, 1'b0, 31, 31, 0, 15, 1);
      to_visit(3); check("keyoff_edge", 32'(eg_o), 32);
      to_visit(3); check("release_48", 32'(eg_o), 48);
      to_visit(3); check("release_64", 32'(eg_o), 64);

      // Key-on with a slow attack: edge visit applies no step.
      cfg_slot(3, 1'b1, 10, 0, 0, 15, 0);
      to_visit(3); check("keyon_no_step", 32'(eg_o), 64);

      // Frozen while clk_en is low.
      run(5, 0);

      // Long run across an eg_cnt wrap: slot 0 R=30, slot 1 R=4, slot 2 fast release.
      cfg_slot(0, 1'b1, 15, 0, 0, 0, 15);
      cfg_slot(1, 1'b1, 2, 0, 0, 0, 15);
      cfg_slot(2, 1'b0, 0, 0, 0, 15, 0);
      run((1 << CNTW) * SLOTS + 200, 100);
      run(5, 0);

      // Randomised configurations with sparse clk_en, and a mid-run reset.
      for (int blk = 0; blk < 60; blk++) begin
         for (int s = 0; s < SLOTS; s++) if ($urandom_range(1) == 1) cfg_random(s);
         run(50, 80);
         if (blk == 30) do_reset(1);
      end
      run(3, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/jt12_eg_tdm.md
Name: jt12_eg_tdm

Overview:
Parametrised, time-multiplexed ADSR envelope generator for SLOTS operator slots. It stores per-slot state and attenuation in indexed registers rather than shift chains. Each clk_en visits one slot, applies key edges, rate stepping and state transitions, then emits that slot's registered attenuation. It sits between the register/operator sequencer and the operator attenuation input.

Parameters:
SLOTS, 24, operator slots serviced round-robin (≥2)
EGW, 10, attenuation width; all-ones = silent
CNTW, 15, global envelope counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
clk_en  in  1  cycle enable; nothing advances when low
slot_o  out  $clog2(SLOTS)  slot whose inputs are sampled this cycle
keyon  in  1  key state for slot_o
ar, d1r, d2r  in  5 each  attack / decay / sustain rates
rr  in  4  release rate
sl  in  4  sustain level
keycode  in  5  key code for key scaling
ks  in  2  key-scale depth
eg_o  out  EGW  attenuation of eg_slot_o
eg_slot_o  out  $clog2(SLOTS)  slot tag of eg_o

Behaviour:
- Reset: slot_o=0, eg_cnt=0; every slot level=all-ones, state=RELEASE, keyon_last=0; eg_o=all-ones, eg_slot_o=0.
- slot_o increments per clk_en, wraps SLOTS-1→0; on that wrap eg_cnt increments, wrapping at 2^CNTW-1→0.
- States: ATTACK, DECAY, SUSTAIN, RELEASE. Base rate: ar / d1r / d2r / {rr,1'b1}.
- Effective rate R (6b): 0 if base=0, else min(63, 2*base + (keycode >> (3-ks))).
- Step: R=0 never; shift = max(0, 11-R[5:2]); step when eg_cnt[shift-1:0]==0 (shift 0 always). amount = R≥48 ? 1<<(R[5:2]-11) : 1.
- Key-on edge (keyon & ~keyon_last): state→ATTACK; level→0 if R_attack≥62, else unchanged. Edge handling overrides stepping that visit.
- Key-off edge: state→RELEASE from any state, no step that visit.
- ATTACK step: level -= ((level*amount)>>4)+1, floor 0. Level 0 in ATTACK (after update) → DECAY.
- DECAY / SUSTAIN / RELEASE step: level += amount, saturating at all-ones.
- Sustain threshold: sl=15 → all-ones, else sl<<(EGW-5). DECAY with level ≥ threshold after update → SUSTAIN.
- keyon_last[slot] <= keyon every visit.
- Latency: inputs for slot s are sampled on the edge where slot_o==s. eg_o/eg_slot_o hold s's updated level after that edge (1 cycle).
- clk_en low: slot_o, eg_cnt, storage and outputs hold.
- rst mid-operation: all slots reinitialised on the next edge, regardless of clk_en.

Optional Feature:
JT12_EG_AM_EN: adds inputs tl[6:0] and am[EGW-1:0]; eg_o = min(all-ones, level + (tl<<(EGW-7)) + am), evaluated for slot_o. Stored level is unaffected.
Without the macro: these ports are absent and eg_o = raw level.

Decomposition:
- Package jt12_eg_pkg: state enum (ATTACK=0, DECAY=1, SUSTAIN=2, RELEASE=3), functions eff_rate(), step_shift(), step_amount(), sustain threshold.
- Sub-module jt12_eg_step: combinational per-visit next-level/next-state logic, taking R, eg_cnt, level and state. The top holds the slot counter, eg_cnt, storage and output registers.

Test Plan:
- rst held 2 cycles → eg_o=0x3FF, eg_slot_o=0, slot_o=0; first clk_en visits report 0x3FF for every slot.
- Slot 3: keyon=1, ar=31, keycode=0, ks=0 (R=62) → after slot-3 visit eg_o=0x000, eg_slot_o=3; next visit state DECAY.
- Slot 0: ar=15, keycode=0 (R=30, shift 4), level 0x3FF → drops to 959 only on visits where eg_cnt[3:0]==0; no change on other visits.
- After instant attack: sl=1, d1r=31 (R=62, amount 16) → 16, then 32 → SUSTAIN; d2r=0 holds 32.
- Keyoff mid-attack, rr=15 (R=62) → RELEASE; +16 per visit, saturating at 0x3FF. Keyon and step on the same visit → keyon takes effect and no step is applied.
- Preload eg_cnt to 0x7FFF, slot R=4 (shift 10) → eg_cnt wraps to 0 and the step occurs; clk_en low for 5 cycles → all outputs frozen.
